// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared constants and helpers for the traffic emulator.
//   - Light codes as driven by the intersection controller (one-hot r/y/g).
//   - Galois LFSR feedback mask and single-step helper.
//   - Lane group masks (bit i-1 = lane i).
//   - Conflict monitor state encoding.
// No ports; imported by lane_queue and traffic_emulator.
package traffic_pkg;

   localparam logic [2:0]  RYG_RED    = 3'b001;
   localparam logic [2:0]  RYG_YELLOW = 3'b010;
   localparam logic [2:0]  RYG_GREEN  = 3'b100;

   localparam logic [15:0] LFSR_MASK  = 16'hB400;

   // Lanes 1/3 share a right of way, lanes 2/4 the crossing one.
   localparam logic [3:0]  GROUP_A    = 4'b0101;
   localparam logic [3:0]  GROUP_B    = 4'b1010;

   // DISARMED: no tick seen since reset, all-zero light codes are tolerated.
   // ARMED:    every cycle is checked strictly.
   // TRIPPED:  a violation was seen; held until reset.
   typedef enum logic [1:0] {
      MON_DISARMED = 2'd0,
      MON_ARMED    = 2'd1,
      MON_TRIPPED  = 2'd2
   } mon_state_t;

   function automatic logic ryg_legal(input logic [2:0] code);
      return (code == RYG_RED) || (code == RYG_YELLOW) || (code == RYG_GREEN);
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/traffic_emulator_lane_queue.sv
// lane_queue
// One lane's car queue. Updates only on tick: an arrival adds a car, a green
// light with a waiting car releases one, both together cancel out.
// Ports:
//   sclk, rst_n   clock, asynchronous active-low reset
//   tick          one-cycle step pulse
//   arrival       a car arrives this step
//   ryg           lane light {green, yellow, red}
//   q             cars waiting (0..QUEUE_MAX)
//   drop          arrival rejected because the queue is full (valid with tick)
module lane_queue
   import traffic_pkg::*;
#(
   parameter logic [2:0] QUEUE_MAX = 3'd7
) (
   input  logic       sclk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       arrival,
   input  logic [2:0] ryg,
   output logic [2:0] q,
   output logic       drop
);

   logic departure;

   // Only a clean green releases a car; yellow holds the queue.
   assign departure = (ryg == RYG_GREEN) && (q != 3'd0);
   assign drop      = tick && arrival && !departure && (q == QUEUE_MAX);

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 3'd0;
      end else if (tick) begin
         unique case ({arrival, departure})
            2'b10: if (q != QUEUE_MAX) q <= q + 3'd1;
            2'b01: q <= q - 3'd1;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/traffic_emulator.sv
// traffic_emulator
// Traffic side of the four-lane intersection demo: models per-lane car queues
// with pseudo-random arrivals and green-light departures, drives the car
// sensors the light controller reads, and flags unsafe light combinations.
// Ports:
//   sclk, rst_n          clock, asynchronous active-low reset
//   ryg1..ryg4           lane lights, bit0 red, bit1 yellow, bit2 green
//   car_present[3:0]     bit i-1 = lane i queue non-empty
//   queue_len[11:0]      lane i count in bits [3i-1:3i-3]
//   conflict             sticky safety-violation flag
//   tick                 one-cycle simulation step pulse
//   drop_count[7:0]      saturating count of arrivals lost at full queues
// Build option: define TRAFFIC_EMU_DROP_COUNT_EN to enable drop_count;
// otherwise drop_count is tied to 0.
// The conflict monitor state is the internal signal mon_state (mon_state_t).
module traffic_emulator
   import traffic_pkg::*;
#(
   parameter int          TICK_BIT       = 25,
   parameter logic [8:0]  ARRIVAL_THRESH = 9'd64,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1,
   parameter logic [2:0]  QUEUE_MAX      = 3'd7
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic [2:0]  ryg1,
   input  logic [2:0]  ryg2,
   input  logic [2:0]  ryg3,
   input  logic [2:0]  ryg4,
   output logic [3:0]  car_present,
   output logic [11:0] queue_len,
   output logic        conflict,
   output logic        tick,
   output logic [7:0]  drop_count
);

   // An all-zero LFSR would lock up, so a zero seed is replaced.
   localparam logic [15:0]       SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [TICK_BIT:0] CNT_ONE  = 1;

   logic [TICK_BIT:0] cnt;
   logic              prev_bit;
   logic [15:0]       lfsr;

   logic [2:0]        ryg [4];
   logic [7:0]        arr_byte [4];
   logic [3:0]        arrival;
   logic [2:0]        q [4];
   logic [3:0]        lane_drop;

   mon_state_t        mon_state, mon_state_nxt;
   logic              armed_now;
   logic              violation;
   logic              bad_code, a_active, b_active;

   // ---------------------------------------------------------------- timebase
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         prev_bit <= 1'b0;
         lfsr     <= SEED_EFF;
      end else begin
         cnt      <= cnt + CNT_ONE;
         prev_bit <= cnt[TICK_BIT];
         if (tick) lfsr <= lfsr_step(lfsr);
      end
   end

   assign tick = cnt[TICK_BIT] & ~prev_bit;

   // ------------------------------------------------------------------ lanes
   assign ryg[0] = ryg1;
   assign ryg[1] = ryg2;
   assign ryg[2] = ryg3;
   assign ryg[3] = ryg4;

   // Lanes 3/4 use nibble-swapped views so the four lanes are decorrelated.
   assign arr_byte[0] = lfsr[7:0];
   assign arr_byte[1] = lfsr[15:8];
   assign arr_byte[2] = {lfsr[3:0], lfsr[15:12]};
   assign arr_byte[3] = {lfsr[11:8], lfsr[7:4]};

   for (genvar g = 0; g < 4; g++) begin : g_lane
      // 9-bit compare so a threshold of 256 means "always".
      assign arrival[g] = ({1'b0, arr_byte[g]} < ARRIVAL_THRESH);

      lane_queue #(.QUEUE_MAX(QUEUE_MAX)) u_lane (
         .sclk    (sclk),
         .rst_n   (rst_n),
         .tick    (tick),
         .arrival (arrival[g]),
         .ryg     (ryg[g]),
         .q       (q[g]),
         .drop    (lane_drop[g])
      );

      assign car_present[g]     = (q[g] != 3'd0);
      assign queue_len[3*g +: 3] = q[g];
   end

   // -------------------------------------------------------- conflict monitor
   // The tick cycle itself already counts as armed.
   always_comb begin
      armed_now = (mon_state != MON_DISARMED) || tick;
      bad_code  = 1'b0;
      a_active  = 1'b0;
      b_active  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         // Before arming, a dark lane (000) is the controller still booting.
         if (armed_now || (ryg[i] != 3'b000)) begin
            if (!ryg_legal(ryg[i])) bad_code = 1'b1;
            if (ryg[i] != RYG_RED) begin
               if (GROUP_A[i]) a_active = 1'b1;
               if (GROUP_B[i]) b_active = 1'b1;
            end
         end
      end
      violation = bad_code || (a_active && b_active);
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) mon_state <= MON_DISARMED;
      else        mon_state <= mon_state_nxt;
   end

   always_comb begin
      mon_state_nxt = mon_state;
      unique case (mon_state)
         MON_DISARMED: begin
            if (violation)  mon_state_nxt = MON_TRIPPED;
            else if (tick)  mon_state_nxt = MON_ARMED;
         end
         MON_ARMED: begin
            if (violation)  mon_state_nxt = MON_TRIPPED;
         end
         MON_TRIPPED: mon_state_nxt = MON_TRIPPED;
         default:     mon_state_nxt = MON_DISARMED;
      endcase
   end

   assign conflict = (mon_state == MON_TRIPPED);

   // -------------------------------------------------------- drop accumulator
`ifdef TRAFFIC_EMU_DROP_COUNT_EN
   logic [2:0] drops_now;
   logic [8:0] drop_sum;

   assign drops_now = {2'b00, lane_drop[0]} + {2'b00, lane_drop[1]}
                    + {2'b00, lane_drop[2]} + {2'b00, lane_drop[3]};
   assign drop_sum  = {1'b0, drop_count} + {6'b000000, drops_now};

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n)        drop_count <= 8'd0;
      else if (drop_sum[8]) drop_count <= 8'hFF;
      else               drop_count <= drop_sum[7:0];
   end
`else
   logic unused_drops;
   assign unused_drops = |lane_drop;
   assign drop_count   = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_emulator.sv
// tb_traffic_emulator
// Three emulator instances share one set of lights:
//   d0: arrivals always (THRESH 256), QUEUE_MAX 7
//   d1: THRESH 100, QUEUE_MAX 3, seed 0 (must behave as seed 1)
//   d2: arrivals never (THRESH 0)
// A bench-side reference model pushes the expected queue/sensor/drop values of
// every step into exp_q; they are popped and compared the cycle after the tick.
// tick and conflict are compared against the model every cycle, and fixed
// checkpoints from the intersection demo are compared against constants.
module tb_traffic_emulator;
   import traffic_pkg::*;

   localparam int TB = 3;  // TICK_BIT: period 16, first tick at cnt 8

   logic        sclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  lt [4];

   logic [3:0]  cp [3];
   logic [11:0] ql [3];
   logic        cf [3];
   logic        tk [3];
   logic [7:0]  dc [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 sclk = ~sclk;

   traffic_emulator #(.TICK_BIT(TB), .ARRIVAL_THRESH(9'd256), .LFSR_SEED(16'hACE1), .QUEUE_MAX(3'd7)) d0 (
      .sclk(sclk), .rst_n(rst_n), .ryg1(lt[0]), .ryg2(lt[1]), .ryg3(lt[2]), .ryg4(lt[3]),
      .car_present(cp[0]), .queue_len(ql[0]), .conflict(cf[0]), .tick(tk[0]), .drop_count(dc[0]));
   traffic_emulator #(.TICK_BIT(TB), .ARRIVAL_THRESH(9'd100), .LFSR_SEED(16'h0000), .QUEUE_MAX(3'd3)) d1 (
      .sclk(sclk), .rst_n(rst_n), .ryg1(lt[0]), .ryg2(lt[1]), .ryg3(lt[2]), .ryg4(lt[3]),
      .car_present(cp[1]), .queue_len(ql[1]), .conflict(cf[1]), .tick(tk[1]), .drop_count(dc[1]));
   traffic_emulator #(.TICK_BIT(TB), .ARRIVAL_THRESH(9'd0), .LFSR_SEED(16'h1234), .QUEUE_MAX(3'd7)) d2 (
      .sclk(sclk), .rst_n(rst_n), .ryg1(lt[0]), .ryg2(lt[1]), .ryg3(lt[2]), .ryg4(lt[3]),
      .car_present(cp[2]), .queue_len(ql[2]), .conflict(cf[2]), .tick(tk[2]), .drop_count(dc[2]));

   // ------------------------------------------------------------ check task
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------- reference model
   function automatic int thr_of(input int k);
      case (k)
         0: return 256;
         1: return 100;
         default: return 0;
      endcase
   endfunction

   function automatic int qmax_of(input int k);
      return (k == 1) ? 3 : 7;
   endfunction

   function automatic logic [15:0] seed_of(input int k);
      case (k)
         0: return 16'hACE1;
         1: return 16'h0001;
         default: return 16'h1234;
      endcase
   endfunction

   function automatic logic [15:0] m_lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [7:0] m_byte(input logic [15:0] s, input int j);
      case (j)
         0: return s[7:0];
         1: return s[15:8];
         2: return {s[3:0], s[15:12]};
         default: return {s[11:8], s[7:4]};
      endcase
   endfunction

   function automatic logic [3:0] cp_of(input logic [11:0] q);
      return {q[11:9] != 3'd0, q[8:6] != 3'd0, q[5:3] != 3'd0, q[2:0] != 3'd0};
   endfunction

   logic [3:0]  m_cnt;
   logic        m_prev, m_armed, m_conflict, m_pend;
   logic [15:0] m_lfsr [3];
   logic [11:0] m_q [3];
   logic [7:0]  m_drop [3];

   logic        m_tick;
   logic [11:0] m_q_n [3];
   logic [7:0]  m_drop_n [3];
   int          m_nd [3];
   logic        m_viol, a_on, b_on, m_pre;

   logic [71:0] exp_q [$];

   assign m_tick = m_cnt[3] & ~m_prev;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         m_q_n[k] = m_q[k];
         m_nd[k]  = 0;
         for (int j = 0; j < 4; j++) begin
            logic [2:0] qj;
            logic       arr, dep;
            qj  = m_q[k][3*j +: 3];
            arr = (int'(m_byte(m_lfsr[k], j)) < thr_of(k));
            dep = (lt[j] == 3'b100) && (qj != 3'd0);
            if (arr && !dep) begin
               if (int'(qj) == qmax_of(k)) m_nd[k] = m_nd[k] + 1;
               else m_q_n[k][3*j +: 3] = qj + 3'd1;
            end else if (dep && !arr) begin
               m_q_n[k][3*j +: 3] = qj - 3'd1;
            end
         end
`ifdef TRAFFIC_EMU_DROP_COUNT_EN
         m_drop_n[k] = ((int'(m_drop[k]) + m_nd[k]) > 255) ? 8'hFF : 8'(int'(m_drop[k]) + m_nd[k]);
`else
         m_drop_n[k] = 8'd0;
`endif
      end
   end

   always_comb begin
      m_pre  = !(m_armed || m_tick);
      m_viol = 1'b0;
      a_on   = 1'b0;
      b_on   = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (!(m_pre && lt[j] == 3'b000)) begin
            if (lt[j] != 3'b001 && lt[j] != 3'b010 && lt[j] != 3'b100) m_viol = 1'b1;
            if (lt[j] != 3'b001) begin
               if (j == 0 || j == 2) a_on = 1'b1;
               else                  b_on = 1'b1;
            end
         end
      end
      if (a_on && b_on) m_viol = 1'b1;
   end

   always @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt      <= 4'd0;
         m_prev     <= 1'b0;
         m_armed    <= 1'b0;
         m_conflict <= 1'b0;
         m_pend     <= 1'b0;
         for (int k = 0; k < 3; k++) begin
            m_lfsr[k] <= seed_of(k);
            m_q[k]    <= 12'd0;
            m_drop[k] <= 8'd0;
         end
         exp_q.delete();
      end else begin
         m_cnt  <= m_cnt + 4'd1;
         m_prev <= m_cnt[3];
         m_pend <= m_tick;
         if (m_viol) m_conflict <= 1'b1;
         if (m_tick) begin
            m_armed <= 1'b1;
            for (int k = 0; k < 3; k++) begin
               m_lfsr[k] <= m_lfsr_next(m_lfsr[k]);
               m_q[k]    <= m_q_n[k];
               m_drop[k] <= m_drop_n[k];
            end
            exp_q.push_back({m_drop_n[2], cp_of(m_q_n[2]), m_q_n[2],
                             m_drop_n[1], cp_of(m_q_n[1]), m_q_n[1],
                             m_drop_n[0], cp_of(m_q_n[0]), m_q_n[0]});
         end
      end
   end

   // ------------------------------------------------------------- scoreboard
   always @(negedge sclk) begin
      logic [71:0] e;
      logic [23:0] ek;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("d%0d_tick", k), 32'(tk[k]), 32'(m_tick));
         check($sformatf("d%0d_conflict", k), 32'(cf[k]), 32'(m_conflict));
      end
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_rst_qlen", k), 32'(ql[k]), 32'd0);
            check($sformatf("d%0d_rst_cp", k), 32'(cp[k]), 32'd0);
            check($sformatf("d%0d_rst_drop", k), 32'(dc[k]), 32'd0);
         end
      end else if (m_pend) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
               ek = e[24*k +: 24];
               check($sformatf("d%0d_qlen", k), 32'(ql[k]), 32'(ek[11:0]));
               check($sformatf("d%0d_cp", k), 32'(cp[k]), 32'(ek[15:12]));
               check($sformatf("d%0d_drop", k), 32'(dc[k]), 32'(ek[23:16]));
            end
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic cyc(input int n);
      repeat (n) @(posedge sclk);
      #1;
   endtask

   task automatic all_red();
      for (int j = 0; j < 4; j++) lt[j] = RYG_RED;
   endtask

   function automatic logic [2:0] pick_light();
      case ($urandom_range(0, 2))
         0: return RYG_RED;
         1: return RYG_YELLOW;
         default: return RYG_GREEN;
      endcase
   endfunction

   // Only one group ever leaves red, so random lights stay conflict-free.
   task automatic random_lights();
      int grp;
      all_red();
      grp = $urandom_range(0, 2);
      if (grp == 1) begin
         lt[0] = pick_light();
         lt[2] = pick_light();
      end else if (grp == 2) begin
         lt[1] = pick_light();
         lt[3] = pick_light();
      end
   endtask

   // --------------------------------------------------------------- sequence
   initial begin
      for (int j = 0; j < 4; j++) lt[j] = 3'b000;
      rst_n = 1'b0;
      cyc(3);
      check("rst_cp", 32'(cp[0]), 32'd0);
      check("rst_conflict", 32'(cf[0]), 32'd0);
      rst_n = 1'b1;

      // Dark lights before the first tick are tolerated.
      cyc(4);
      check("prearm_dark", 32'(cf[0]), 32'd0);
      all_red();
      cyc(3);
      check("tick_cnt7", 32'(tk[0]), 32'd0);
      cyc(1);
      check("tick_cnt8", 32'(tk[0]), 32'd1);
      cyc(1);
      check("fill_t1_cp", 32'(cp[0]), 32'hF);
      check("fill_t1_qlen", 32'(ql[0]), 32'h249);
      check("never_t1_cp", 32'(cp[2]), 32'd0);
      cyc(15);
      check("tick_cnt24", 32'(tk[0]), 32'd1);

      // Saturation after tick 7.
      cyc(81);
      check("fill_t7_qlen", 32'(ql[0]), 32'hFFF);
      check("fill_t7_drop", 32'(dc[0]), 32'd0);

      // Ten more ticks at full queues: four drops each.
      cyc(160);
      check("sat_qlen", 32'(ql[0]), 32'hFFF);
`ifdef TRAFFIC_EMU_DROP_COUNT_EN
      check("drop_40", 32'(dc[0]), 32'd40);
`else
      check("drop_off", 32'(dc[0]), 32'd0);
`endif

      // Green lane 1 with certain arrivals: departure and arrival cancel.
      lt[0] = RYG_GREEN;
      cyc(48);
      check("green_hold_qlen", 32'(ql[0]), 32'hFFF);

      // Random legal lights exercise departures on d1.
      for (int t = 0; t < 30; t++) begin
         random_lights();
         cyc(16);
      end

      all_red();
      cyc(64 * 16);
`ifdef TRAFFIC_EMU_DROP_COUNT_EN
      check("drop_sat", 32'(dc[0]), 32'd255);
`else
      check("drop_off_end", 32'(dc[0]), 32'd0);
`endif
      check("never_qlen", 32'(ql[2]), 32'd0);

      // Group conflict for a single cycle.
      lt[0] = RYG_GREEN;
      lt[1] = RYG_YELLOW;
      cyc(1);
      all_red();
      check("grp_conflict", 32'(cf[0]), 32'd1);
      cyc(20);
      check("grp_conflict_sticky", 32'(cf[0]), 32'd1);

      // Mid-operation reset clears everything, including conflict.
      rst_n = 1'b0;
      #2;
      check("rst_clear_conflict", 32'(cf[0]), 32'd0);
      check("rst_clear_qlen", 32'(ql[0]), 32'd0);
      cyc(2);
      rst_n = 1'b1;

      cyc(2);
      lt[2] = 3'b000;
      cyc(4);
      check("prearm_zero_ok", 32'(cf[0]), 32'd0);
      lt[2] = RYG_RED;
      cyc(4);
      lt[2] = 3'b011;
      cyc(1);
      lt[2] = RYG_RED;
      check("bad_code_conflict", 32'(cf[0]), 32'd1);
      check("bad_code_conflict_d1", 32'(cf[1]), 32'd1);
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_emulator.md
# traffic_emulator

Traffic-side companion to the four-lane intersection light controller. It consumes the controller's per-lane red/yellow/green drives, models a car queue per lane with pseudo-random arrivals and green-light departures, and produces the car-present sensor signals the controller reads. It also flags unsafe or malformed light combinations. It is used for closed-loop on-board demos and as the stimulus/checker partner in simulation.

## Interface
- TICK_BIT, 25: the simulation step ("tick") fires when free-running counter bit TICK_BIT rises. This matches the controller's step rate.
- ARRIVAL_THRESH, 9'd64: per-lane arrival probability is ARRIVAL_THRESH/256 per tick. 0 means never; 256 means always.
- LFSR_SEED, 16'hACE1: initial LFSR state. A value of 0 is replaced by 16'h0001.
- QUEUE_MAX, 7: queue saturation limit, 1..7.

Ports:
- sclk  in  1  sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ryg1, ryg2, ryg3, ryg4  in  3 each  lane lights. bit0 = red, bit1 = yellow, bit2 = green.
- car_present  out  4  bit i-1 is high when the lane i queue is non-empty.
- queue_len  out  12  lane i count in bits [3i-1:3i-3].
- conflict  out  1  sticky safety-violation flag.
- tick  out  1  one-cycle step pulse.
- drop_count  out  8  arrivals rejected at full queues (see Configuration).

## Operation
- The lanes form two groups: lanes 1/3 are group A and lanes 2/4 are group B.
- Free-running counter cnt, width TICK_BIT+1, increments every cycle. It wraps silently.
- tick = cnt[TICK_BIT] & ~prev_bit, where prev_bit is a register holding cnt[TICK_BIT] from the previous cycle.
- LFSR: 16-bit Galois with mask 16'hB400, shifted right. It advances once per tick.
- Per-lane arrival byte:
  - lane 1: lfsr[7:0]
  - lane 2: lfsr[15:8]
  - lane 3: {lfsr[3:0], lfsr[15:12]}
  - lane 4: {lfsr[11:8], lfsr[7:4]}
- arrival_i = ({1'b0, byte_i} < ARRIVAL_THRESH), evaluated with the pre-advance LFSR value.
- departure_i = (ryg_i == 3'b100) && (q_i != 0). Yellow does not release cars.
- Queue update on tick:
  - arrival and departure together: q is unchanged.
  - arrival only: q+1; if q == QUEUE_MAX, q holds and the arrival is a drop.
  - departure only: q-1.
  - neither: q holds.
- car_present_i = (q_i != 0), combinational from the registered q.
- Conflict monitor:
  - Runs every cycle. It is armed from the first tick after reset; before that, all-zero light codes are ignored.
  - Violation (a): any ryg_i not in {001, 010, 100}.
  - Violation (b): any group-A lane non-red while any group-B lane is non-red.
  - conflict is set the cycle after a violation and stays set until reset.

## Timing
- Reset values:
  - cnt = 0, prev_bit = 0, lfsr = seed.
  - All q = 0, car_present = 0, queue_len = 0.
  - conflict = 0, tick = 0, drop_count = 0, monitor disarmed.
- First tick occurs when cnt == 2^TICK_BIT. Period is 2^(TICK_BIT+1) cycles.
- Lights are sampled in the tick cycle. queue_len and car_present reflect the update in the following cycle.
- Reset asserted mid-operation clears all state immediately, including the sticky conflict flag.

## Configuration
- TRAFFIC_EMU_DROP_COUNT_EN defined:
  - drop_count adds the number of lanes that dropped an arrival this tick (0..4).
  - It saturates at 255.
- Not defined:
  - drop_count is tied to 0.
  - No drop logic is synthesized.

## Structure
- Package traffic_pkg holds:
  - RYG_RED = 3'b001, RYG_YELLOW = 3'b010, RYG_GREEN = 3'b100
  - LFSR_MASK = 16'hB400
  - lane group constants (GROUP_A = lanes 1/3, GROUP_B = lanes 2/4)
- Sub-module lane_queue is instantiated four times.
  - Inputs: tick, arrival, ryg.
  - Outputs: q, drop.
- The top level holds the counter, LFSR, monitor and drop accumulator.

## Test plan
Benches use TICK_BIT=3, so the tick period is 16 cycles and the first tick lands at cnt == 8.
- Reset/tick timing: hold rst_n low, then release. Required: all outputs 0; tick high at cnt 8, 24, 40; no conflict flagged before the first tick.
- Fill to saturation: all lanes red (3'b001), ARRIVAL_THRESH=256. Required: car_present = 4'b1111 after tick 1; each lane count reaches 7 after tick 7 and holds.
- Drain: from full, drive ryg1 = 100 with the others red and ARRIVAL_THRESH=0. Required: lane 1 count drops by 1 per tick; car_present[0] goes low the cycle after tick 7; lanes 2-4 stay at 7. With ARRIVAL_THRESH=256 instead, lane 1 holds at 7.
- Group conflict: after the first tick, drive ryg1 = 100 and ryg2 = 010 for one cycle, then restore legal lights. Required: conflict goes to 1 the next cycle and stays 1; pulsing rst_n clears it.
- Invalid code: drive ryg3 = 3'b011 after arming. Required: conflict = 1. Drive ryg3 = 3'b000 before the first tick. Required: conflict stays 0.
- Drop count (macro defined): all lanes full, all red, THRESH=256, 10 further ticks. Required: drop_count = 40. After 64 ticks: 255 (saturated). With the macro undefined: drop_count stays 0.
